// File: rtl/cfg_pkg.sv
// Shared configuration for the Si5340-style I2C register target:
// default address, byte width, transfer direction and FSM state encoding.
package cfg_pkg;

  localparam int         DATA_WIDTH = 8;
  localparam logic [6:0] SLAVE_ADDR = 7'h74;

  typedef logic [DATA_WIDTH-1:0] byte_t;

  typedef enum logic {
    R_W_WRITE = 1'b0,
    R_W_READ  = 1'b1
  } r_w;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ACK_ADDR,
    ST_REG,
    ST_ACK_REG,
    ST_WDATA,
    ST_ACK_WDATA,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// Brings SCL/SDA into the clk_i domain and flags SCL edges plus START/STOP
// conditions, all derived from the synchronized copies only.
module i2c_line_sync (
  input  logic clk_i,
  input  logic arstn_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic sda_o,
  output logic scl_rise_o,
  output logic scl_fall_o,
  output logic start_o,
  output logic stop_o
);

  logic [1:0] scl_sync_q;
  logic [1:0] sda_sync_q;
  logic       scl_prev_q;
  logic       sda_prev_q;

  // NOTE: sequential state is only ever updated with non-blocking assignments.
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_prev_q <= 1'b1;
      sda_prev_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[0], scl_i};
      sda_sync_q <= {sda_sync_q[0], sda_i};
      scl_prev_q <= scl_sync_q[1];
      sda_prev_q <= sda_sync_q[1];
    end
  end

  assign sda_o      = sda_sync_q[1];
  assign scl_rise_o = scl_sync_q[1] & ~scl_prev_q;
  assign scl_fall_o = ~scl_sync_q[1] & scl_prev_q;
  // SDA may only move while SCL is high for START/STOP, so require SCL high on both samples.
  assign start_o    = scl_sync_q[1] & scl_prev_q & sda_prev_q & ~sda_sync_q[1];
  assign stop_o     = scl_sync_q[1] & scl_prev_q & ~sda_prev_q & sda_sync_q[1];

endmodule

// File: rtl/si5340_i2c_target.sv
// Si5340-style I2C register target: paged register file with an auto-incrementing
// pointer; pointer 0x01 doubles as the page select. Register contents survive reset.
module si5340_i2c_target
  import cfg_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = cfg_pkg::SLAVE_ADDR,
  parameter int         PAGE_COUNT = 16,
  parameter string      INIT_MEM   = ""
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        sda_oen_o,
  output logic        wr_valid_o,
  output logic [15:0] wr_addr_o,
  output logic [7:0]  wr_data_o,
  output logic        busy_o
);

  localparam int MEM_DEPTH = PAGE_COUNT * 256;
  localparam int MEM_AW    = $clog2(MEM_DEPTH);

  logic        sda_s, scl_rise, scl_fall, start_det, stop_det;
  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  byte_t       shreg_q, shreg_d, tx_q, tx_d;
  byte_t       page_q, page_d, ptr_q, ptr_d;
  logic        phase_q, phase_d, busy_q, busy_d;
  r_w          rw_q, rw_d;
  logic        wr_valid_q, wr_valid_d;
  logic [15:0] wr_addr_q, wr_addr_d;
  byte_t       wr_data_q, wr_data_d;
  byte_t       rx_byte, rd_byte, wr_page;
  logic [15:0] rd_addr;
  byte_t       mem [MEM_DEPTH];

  i2c_line_sync u_line_sync (
    .clk_i      (clk_i),
    .arstn_i    (arstn_i),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_o      (sda_s),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall),
    .start_o    (start_det),
    .stop_o     (stop_det)
  );

  // NOTE: the register array has no reset branch so its contents survive arstn_i.
  always_ff @(posedge clk_i) begin
    if (wr_valid_q) mem[wr_addr_q[MEM_AW-1:0]] <= wr_data_q;
  end

  assign rx_byte = {shreg_q[6:0], sda_s};
  assign wr_page = byte_t'(int'(rx_byte) % PAGE_COUNT);
  assign rd_addr = {page_q, ptr_q};
  assign rd_byte = (ptr_q == 8'h01) ? page_q : mem[rd_addr[MEM_AW-1:0]];

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shreg_q    <= '0;
      tx_q       <= '1;
      page_q     <= '0;
      ptr_q      <= '0;
      phase_q    <= 1'b0;
      busy_q     <= 1'b0;
      rw_q       <= R_W_WRITE;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shreg_q    <= shreg_d;
      tx_q       <= tx_d;
      page_q     <= page_d;
      ptr_q      <= ptr_d;
      phase_q    <= phase_d;
      busy_q     <= busy_d;
      rw_q       <= rw_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shreg_d    = shreg_q;
    tx_d       = tx_q;
    page_d     = page_q;
    ptr_d      = ptr_q;
    phase_d    = phase_q;
    busy_d     = busy_q;
    rw_d       = rw_q;
    wr_valid_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (stop_det) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      phase_d = 1'b0;
    end else if (start_det) begin
      state_d   = ST_ADDR;
      bit_cnt_d = '0;
      phase_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_ADDR, ST_REG, ST_WDATA: begin
          if (scl_rise) begin
            shreg_d   = rx_byte;
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              if (state_q == ST_ADDR) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_d = ST_ACK_ADDR;
                  rw_d    = r_w'(rx_byte[0]);
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_REG) begin
                ptr_d   = rx_byte;
                state_d = ST_ACK_REG;
              end else begin
                wr_valid_d = 1'b1;
                wr_data_d  = rx_byte;
                wr_addr_d  = {(ptr_q == 8'h01) ? wr_page : page_q, ptr_q};
                if (ptr_q == 8'h01) page_d = wr_page;
                ptr_d   = ptr_q + 8'd1;
                state_d = ST_ACK_WDATA;
              end
            end
          end
        end
        // First SCL fall starts driving the ACK low, the second one ends the ACK slot.
        ST_ACK_ADDR, ST_ACK_REG, ST_ACK_WDATA: begin
          if (scl_fall) begin
            phase_d = ~phase_q;
            if (phase_q) begin
              if (state_q == ST_ACK_ADDR && rw_q == R_W_READ) begin
                tx_d      = rd_byte;
                ptr_d     = ptr_q + 8'd1;
                bit_cnt_d = '0;
                state_d   = ST_RDATA;
              end else if (state_q == ST_ACK_ADDR) begin
                state_d = ST_REG;
              end else begin
                state_d = ST_WDATA;
              end
            end
          end
        end
        ST_RDATA: begin
          if (scl_fall) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_d = ST_RACK;
            else tx_d = {tx_q[6:0], 1'b1};
          end
        end
        ST_RACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end else begin
              phase_d = 1'b1;
            end
          end else if (scl_fall && phase_q) begin
            phase_d   = 1'b0;
            tx_d      = rd_byte;
            ptr_d     = ptr_q + 8'd1;
            bit_cnt_d = '0;
            state_d   = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    unique case (state_q)
      ST_ACK_ADDR, ST_ACK_REG, ST_ACK_WDATA: sda_oen_o = ~phase_q;
      ST_RDATA:                              sda_oen_o = tx_q[7];
      default:                               sda_oen_o = 1'b1;
    endcase
  end

  assign sda_o      = 1'b0;
  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;
  assign busy_o     = busy_q;

endmodule

// File: tb/tb_si5340_i2c_target.sv
// Bit-level I2C master driving si5340_i2c_target, checked against a
// transaction-level register-file model (page/pointer/memory arrays).
module tb_si5340_i2c_target;

  localparam int QCLK = 8;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        scl_m = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_line;
  logic        sda_o, sda_oen_o, wr_valid_o, busy_o;
  logic [15:0] wr_addr_o;
  logic [7:0]  wr_data_o;

  assign sda_line = sda_m & (sda_oen_o ? 1'b1 : sda_o);

  si5340_i2c_target dut (
    .clk_i      (clk),
    .arstn_i    (arstn),
    .scl_i      (scl_m),
    .sda_i      (sda_line),
    .sda_o      (sda_o),
    .sda_oen_o  (sda_oen_o),
    .wr_valid_o (wr_valid_o),
    .wr_addr_o  (wr_addr_o),
    .wr_data_o  (wr_data_o),
    .busy_o     (busy_o)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_pass = 0;
  logic [23:0] wr_log [$];
  int          wr_idx = 0;
  int          busy_cycles = 0;

  always @(negedge clk) begin
    if (wr_valid_o === 1'b1) wr_log.push_back({wr_addr_o, wr_data_o});
    if (busy_o === 1'b1) busy_cycles++;
  end

  // Reference model: register pages, pointer and page select at transaction level.
  logic [7:0] m_mem [16*256];
  int         m_page = 0;
  int         m_ptr = 0;
  logic [7:0] wbuf [4];
  logic [7:0] rd_last;

  function automatic logic [15:0] model_write(input logic [7:0] d);
    if (m_ptr == 1) m_page = int'(d) % 16;
    model_write = 16'(m_page * 256 + m_ptr);
    m_mem[m_page * 256 + m_ptr] = d;
    m_ptr = (m_ptr + 1) % 256;
  endfunction

  function automatic logic [7:0] model_read();
    model_read = (m_ptr == 1) ? 8'(m_page) : m_mem[m_page * 256 + m_ptr];
    m_ptr = (m_ptr + 1) % 256;
  endfunction

  task automatic qwait();
    repeat (QCLK) @(negedge clk);
  endtask

  task automatic start_cond();
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b0; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic stop_cond();
    sda_m = 1'b0; qwait(); scl_m = 1'b1; qwait(); sda_m = 1'b1; qwait();
  endtask

  task automatic put_bit(input logic b);
    sda_m = b; qwait(); scl_m = 1'b1; qwait(); qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic get_bit(output logic b);
    sda_m = 1'b1; qwait(); scl_m = 1'b1; qwait(); b = sda_line; qwait(); scl_m = 1'b0; qwait();
  endtask

  task automatic send_byte(input logic [7:0] b, output bit acked);
    logic a;
    for (int i = 7; i >= 0; i--) put_bit(b[i]);
    get_bit(a);
    acked = (a === 1'b0);
  endtask

  task automatic recv_byte(input bit m_ack, output logic [7:0] d);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      get_bit(b);
      d[i] = b;
    end
    put_bit(m_ack ? 1'b0 : 1'b1);
  endtask

  task automatic bus_write(input logic [6:0] a7, input logic [7:0] p, input int n, input bit do_stop);
    bit          ack;
    bit          match;
    logic [15:0] ea;
    logic [23:0] got;
    match = (a7 == 7'h74);
    start_cond();
    send_byte({a7, 1'b0}, ack);
    n_checks++;
    if (ack !== match) $display("FAIL addr_ack %h: got %0b expected %0b", a7, ack, match); else n_pass++;
    if (match) begin
      send_byte(p, ack);
      m_ptr = p;
      n_checks++;
      if (ack !== 1'b1) $display("FAIL ptr_ack: got %0b expected 1", ack); else n_pass++;
      for (int i = 0; i < n; i++) begin
        send_byte(wbuf[i], ack);
        ea = model_write(wbuf[i]);
        got = (wr_log.size() > wr_idx) ? wr_log[wr_idx] : 24'hxxxxxx;
        wr_idx++;
        n_checks++;
        if (ack !== 1'b1 || got !== {ea, wbuf[i]})
          $display("FAIL data_write[%0d]: ack %0b event %h, expected ack 1 event %h", i, ack, got, {ea, wbuf[i]});
        else n_pass++;
      end
    end
    if (do_stop) stop_cond();
  endtask

  task automatic bus_read(input int n, input bit set_ptr, input logic [7:0] p);
    bit         ack1, ack2;
    logic [7:0] d, exp_d;
    if (set_ptr) begin
      start_cond();
      send_byte({7'h74, 1'b0}, ack1);
      send_byte(p, ack2);
      m_ptr = p;
      n_checks++;
      if (!(ack1 && ack2)) $display("FAIL rd_ptr_ack: got %0b%0b expected 11", ack1, ack2); else n_pass++;
    end
    start_cond();
    send_byte({7'h74, 1'b1}, ack1);
    n_checks++;
    if (ack1 !== 1'b1) $display("FAIL rd_addr_ack: got %0b expected 1", ack1); else n_pass++;
    for (int i = 0; i < n; i++) begin
      recv_byte(i < n - 1, d);
      exp_d = model_read();
      rd_last = d;
      n_checks++;
      if (d !== exp_d) $display("FAIL rd_data[%0d]: got %h expected %h", i, d, exp_d); else n_pass++;
    end
    n_checks++;
    if (sda_oen_o !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL nack_release: oen %b busy %b expected oen 1 busy 0", sda_oen_o, busy_o);
    else n_pass++;
    stop_cond();
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    for (int i = 0; i < 16 * 256; i++) m_mem[i] = 8'h00;
    repeat (4) @(negedge clk);
    n_checks++; if (sda_oen_o !== 1'b1) $display("FAIL rst_oen: got %b expected 1", sda_oen_o); else n_pass++;
    n_checks++; if (sda_o !== 1'b0) $display("FAIL rst_sda_o: got %b expected 0", sda_o); else n_pass++;
    n_checks++; if (wr_valid_o !== 1'b0) $display("FAIL rst_wr_valid: got %b expected 0", wr_valid_o); else n_pass++;
    n_checks++; if (wr_addr_o !== 16'h0) $display("FAIL rst_wr_addr: got %h expected 0000", wr_addr_o); else n_pass++;
    n_checks++; if (wr_data_o !== 8'h0) $display("FAIL rst_wr_data: got %h expected 00", wr_data_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_busy: got %b expected 0", busy_o); else n_pass++;
    arstn = 1'b1;
    m_page = 0;
    m_ptr = 0;
    repeat (4) @(negedge clk);
    wbuf[0] = 8'h5A;
    bus_write(7'h74, 8'h00, 1, 1'b1);
  endtask

  task automatic test_page_write();
    wbuf[0] = 8'h03;
    bus_write(7'h74, 8'h01, 1, 1'b1);
    n_checks++;
    if (wr_log.size() !== wr_idx || wr_log[wr_idx-1] !== 24'h0301_03)
      $display("FAIL page_write: events %0d last %h expected %0d last 030103", wr_log.size(), wr_log[wr_idx-1], wr_idx);
    else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL busy_after_stop: got %b expected 0", busy_o); else n_pass++;
  endtask

  task automatic test_write_read();
    wbuf[0] = 8'h11;
    wbuf[1] = 8'h22;
    bus_write(7'h74, 8'h2A, 2, 1'b0);
    n_checks++;
    if (wr_log[wr_idx-2] !== 24'h032A_11 || wr_log[wr_idx-1] !== 24'h032B_22)
      $display("FAIL wr_addr_seq: got %h %h expected 032a11 032b22", wr_log[wr_idx-2], wr_log[wr_idx-1]);
    else n_pass++;
    n_checks++; if (busy_o !== 1'b1) $display("FAIL busy_mid_txn: got %b expected 1", busy_o); else n_pass++;
    bus_read(2, 1'b1, 8'h2A);
  endtask

  task automatic test_nack_addr();
    int b0;
    b0 = busy_cycles;
    bus_write(7'h75, 8'h10, 0, 1'b1);
    n_checks++;
    if (busy_cycles !== b0 || wr_log.size() !== wr_idx)
      $display("FAIL foreign_addr: busy cycles %0d events %0d expected 0 and %0d", busy_cycles - b0, wr_log.size(), wr_idx);
    else n_pass++;
  endtask

  task automatic test_wrap();
    wbuf[0] = 8'hAA;
    wbuf[1] = 8'hBB;
    bus_write(7'h74, 8'hFF, 2, 1'b1);
    n_checks++;
    if (wr_log[wr_idx-2][23:8] !== 16'h03FF || wr_log[wr_idx-1][23:8] !== 16'h0300)
      $display("FAIL ptr_wrap: got %h %h expected 03ff 0300", wr_log[wr_idx-2][23:8], wr_log[wr_idx-1][23:8]);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit         ack;
    logic [7:0] p;
    p = 8'h40;
    start_cond();
    send_byte({7'h74, 1'b0}, ack);
    for (int i = 7; i >= 0; i--) put_bit(p[i]);
    sda_m = 1'b1;
    qwait();
    n_checks++; if (sda_oen_o !== 1'b0) $display("FAIL ack_reg_drive: got %b expected 0", sda_oen_o); else n_pass++;
    @(negedge clk);
    arstn = 1'b0;
    #1;
    n_checks++; if (sda_oen_o !== 1'b1) $display("FAIL async_release: got %b expected 1", sda_oen_o); else n_pass++;
    n_checks++; if (busy_o !== 1'b0) $display("FAIL async_busy: got %b expected 0", busy_o); else n_pass++;
    repeat (4) @(negedge clk);
    arstn = 1'b1;
    m_page = 0;
    m_ptr = 0;
    repeat (4) @(negedge clk);
    bus_read(1, 1'b0, 8'h00);
    wbuf[0] = 8'h03;
    bus_write(7'h74, 8'h01, 1, 1'b0);
    bus_read(1, 1'b1, 8'h2A);
    n_checks++; if (rd_last !== 8'h11) $display("FAIL retained_mem: got %h expected 11", rd_last); else n_pass++;
  endtask

  task automatic test_random();
    int         n;
    logic [7:0] p;
    logic [6:0] bad;
    for (int it = 0; it < 6; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        bad = 7'h74 ^ 7'(1 << $urandom_range(0, 6));
        bus_write(bad, 8'h00, 0, 1'b1);
      end
      p = 8'($urandom_range(2, 251));
      n = $urandom_range(1, 4);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
      bus_write(7'h74, p, n, 1'($urandom_range(0, 1)));
      bus_read(n, 1'b1, p);
    end
    n_checks++;
    if (wr_log.size() !== wr_idx) $display("FAIL write_count: got %0d expected %0d", wr_log.size(), wr_idx); else n_pass++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_page_write();
    test_write_read();
    test_nack_addr();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
